// File: rtl/div_pkg.sv
// Shared definitions for the multi-lane sequential divider.
//   - state_t : controller state encoding (IDLE / BUSY / DONE)
//   - NBITS, NDATA : default lane width and lane count
//   - ITER    : restoring steps per bundle at the default width
//   - lane_lo : low bit offset of a lane inside a packed bus
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NBITS = 4;
    localparam int unsigned NDATA = 3;
    localparam int unsigned ITER  = 2 * NBITS;

    function automatic int unsigned lane_lo(input int unsigned lane,
                                            input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/divide_seq_unitary.sv
// One divider lane: restoring division, one quotient bit per step.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load          capture dividend/divisor, clear partial remainder
//   step          perform one restoring step
//   last          this step is the final one; latch the results
//   dividend_i    2*Nbits dividend
//   divisor_i     Nbits divisor
//   quotient_o    2*Nbits quotient (held until the next bundle completes)
//   remainder_o   Nbits remainder
//   div_by_zero_o divisor of the completed bundle was zero
module divide_unitary
    import div_pkg::*;
#(
    parameter int unsigned Nbits = NBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               last,
    input  logic [2*Nbits-1:0] dividend_i,
    input  logic [Nbits-1:0]   divisor_i,
    output logic [2*Nbits-1:0] quotient_o,
    output logic [Nbits-1:0]   remainder_o,
    output logic               div_by_zero_o
);

    logic [Nbits:0]     r_q, r_d;
    logic [2*Nbits-1:0] q_q, q_d;
    logic [Nbits-1:0]   d_q, d_d;
    logic               dbz_q, dbz_d;

    // Result registers are separate from the working registers so the
    // outputs stay frozen through the next bundle's BUSY phase.
    logic [2*Nbits-1:0] quo_q, quo_d;
    logic [Nbits-1:0]   rem_q, rem_d;
    logic               dbz_out_q, dbz_out_d;

    logic [Nbits:0]     r_shift;
    logic [Nbits:0]     r_step;
    logic [2*Nbits-1:0] q_step;
    logic               take;

    always_comb begin
        // Q doubles as the dividend shift register: its MSB feeds R while
        // the new quotient bit enters at the LSB.
        r_shift = {r_q[Nbits-1:0], q_q[2*Nbits-1]};
        take    = (r_shift >= {1'b0, d_q});
        r_step  = take ? (r_shift - {1'b0, d_q}) : r_shift;
        q_step  = {q_q[2*Nbits-2:0], take};

        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        dbz_d     = dbz_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_out_d = dbz_out_q;

        if (load) begin
            r_d   = '0;
            q_d   = dividend_i;
            d_d   = divisor_i;
            dbz_d = (divisor_i == '0);
        end else if (step) begin
            r_d = r_step;
            q_d = q_step;
            // With D=0 every step subtracts nothing, which naturally gives
            // an all-ones quotient and the low dividend bits as remainder.
            if (last) begin
                quo_d     = q_step;
                rem_d     = r_step[Nbits-1:0];
                dbz_out_d = dbz_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            dbz_q     <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            dbz_q     <= dbz_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_out_q;

endmodule

// File: rtl/divide_seq.sv
// Multi-lane sequential unsigned divider. All lanes run in lockstep under
// one controller; a bundle takes 2*Nbits steps after acceptance.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   in_valid     operand bundle valid
//   in_ready     block can accept operands (IDLE only)
//   dividend     Ndata packed 2*Nbits dividends
//   divisor      Ndata packed Nbits divisors
//   out_valid    results valid (DONE)
//   out_ready    consumer accepts results
//   quotient     Ndata packed 2*Nbits quotients
//   remainder    Ndata packed Nbits remainders
//   div_by_zero  per-lane divide-by-zero flag
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready=1
// BUSY  | one restoring step per clock on every lane
// DONE  | results presented, waiting for out_ready
module divide_seq
    import div_pkg::*;
#(
    parameter int unsigned Nbits = NBITS,
    parameter int unsigned Ndata = NDATA
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [Ndata*2*Nbits-1:0] dividend,
    input  logic [Ndata*Nbits-1:0]   divisor,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [Ndata*2*Nbits-1:0] quotient,
    output logic [Ndata*Nbits-1:0]   remainder,
    output logic [Ndata-1:0]         div_by_zero
);

    localparam int unsigned N_ITER = 2 * Nbits;
    localparam int unsigned CW     = $clog2(N_ITER);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic            load;
    logic            step;
    logic            last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        load        = 1'b0;
        step        = 1'b0;
        last        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    load       = 1'b1;
                    cnt_d      = CW'(N_ITER - 1);
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (cnt_q == '0) begin
                    last        = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

    for (genvar i = 0; i < Ndata; i++) begin : g_lane
        divide_unitary #(
            .Nbits(Nbits)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .load         (load),
            .step         (step),
            .last         (last),
            .dividend_i   (dividend[lane_lo(i, 2*Nbits) +: 2*Nbits]),
            .divisor_i    (divisor[lane_lo(i, Nbits) +: Nbits]),
            .quotient_o   (quotient[lane_lo(i, 2*Nbits) +: 2*Nbits]),
            .remainder_o  (remainder[lane_lo(i, Nbits) +: Nbits]),
            .div_by_zero_o(div_by_zero[i])
        );
    end

endmodule

// File: tb/tb_divide_seq.sv
module tb_divide_seq;

    localparam int NB = 4;
    localparam int ND = 3;
    localparam int DW = 2 * NB;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ND*DW-1:0]  dividend;
    logic [ND*NB-1:0]  divisor;
    logic              out_valid;
    logic              out_ready;
    logic [ND*DW-1:0]  quotient;
    logic [ND*NB-1:0]  remainder;
    logic [ND-1:0]     div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    int a_m[ND];
    int b_m[ND];

    always #5 clk = ~clk;

    divide_seq #(.Nbits(NB), .Ndata(ND)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Operands go to the model arrays and onto the ports.
    task automatic set_ops(input int a0, input int a1, input int a2,
                           input int b0, input int b1, input int b2);
        a_m[0] = a0; a_m[1] = a1; a_m[2] = a2;
        b_m[0] = b0; b_m[1] = b1; b_m[2] = b2;
        for (int i = 0; i < ND; i++) begin
            dividend[i*DW +: DW] = a_m[i][DW-1:0];
            divisor[i*NB +: NB]  = b_m[i][NB-1:0];
        end
    endtask

    function automatic int exp_q(input int a, input int b);
        return (b == 0) ? ((1 << DW) - 1) : (a / b);
    endfunction

    function automatic int exp_r(input int a, input int b);
        return (b == 0) ? (a % (1 << NB)) : (a % b);
    endfunction

    task automatic check_results(input string tag);
        for (int i = 0; i < ND; i++) begin
            chk({tag, "_q"},   64'(quotient[i*DW +: DW]),  64'(exp_q(a_m[i], b_m[i])));
            chk({tag, "_r"},   64'(remainder[i*NB +: NB]), 64'(exp_r(a_m[i], b_m[i])));
            chk({tag, "_dbz"}, 64'(div_by_zero[i]),        64'(b_m[i] == 0));
        end
    endtask

    // Called at a negedge with operands on the ports; returns at the negedge
    // after the accept edge with the inputs scrambled.
    task automatic accept();
        in_valid = 1'b1;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = ND*DW'($urandom);
        divisor  = ND*NB'($urandom);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (1) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            chk("in_ready_busy", 64'(in_ready), 64'd0);
            if (out_valid) break;
            if (lat >= 40) begin
                chk("out_valid_timeout", 64'(out_valid), 64'd1);
                break;
            end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", 64'(out_valid), 64'd0);
        chk("in_ready_back",  64'(in_ready),  64'd1);
    endtask

    initial begin
        int lat;
        logic [ND*DW-1:0] q_hold;
        logic [ND*NB-1:0] r_hold;
        int ba[ND];
        int bb[ND];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready",  64'(in_ready),    64'd1);
        chk("rst_out_valid", 64'(out_valid),   64'd0);
        chk("rst_quotient",  64'(quotient),    64'd0);
        chk("rst_remainder", 64'(remainder),   64'd0);
        chk("rst_dbz",       64'(div_by_zero), 64'd0);

        // Basic divide
        set_ops(100, 255, 5, 7, 15, 12);
        accept();
        wait_out(lat);
        chk("basic_latency", 64'(lat), 64'd8);
        check_results("basic");
        chk("basic_q0_const", 64'(quotient[0 +: DW]), 64'd14);
        chk("basic_q1_const", 64'(quotient[DW +: DW]), 64'd17);
        release_out();

        // Divide by zero on lane 2
        set_ops(200, 200, 9, 10, 10, 0);
        accept();
        wait_out(lat);
        chk("dbz_latency", 64'(lat), 64'd8);
        check_results("dbz");
        chk("dbz_flags", 64'(div_by_zero), 64'b100);
        chk("dbz_q2",    64'(quotient[2*DW +: DW]), 64'd255);
        release_out();

        // Backpressure
        set_ops(77, 250, 3, 5, 1, 13);
        accept();
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'd8);
        check_results("bp");
        q_hold = quotient;
        r_hold = remainder;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_q_stable",  64'(quotient),  64'(q_hold));
            chk("bp_r_stable",  64'(remainder), 64'(r_hold));
        end
        release_out();
        chk("bp_q_hold_idle", 64'(quotient), 64'(q_hold));

        // Back-to-back with in_valid held high
        ba[0] = 63; ba[1] = 100; ba[2] = 9;
        bb[0] = 8;  bb[1] = 7;   bb[2] = 0;
        set_ops(ba[0], ba[1], ba[2], bb[0], bb[1], bb[2]);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        set_ops(144, 63, 240, 12, 8, 3);
        a_m[0] = ba[0]; a_m[1] = ba[1]; a_m[2] = ba[2];
        b_m[0] = bb[0]; b_m[1] = bb[1]; b_m[2] = bb[2];
        wait_out(lat);
        chk("b2b_first_latency", 64'(lat), 64'd8);
        check_results("b2b_first");
        chk("b2b_q0_const", 64'(quotient[0 +: DW]), 64'd7);
        @(posedge clk);
        @(negedge clk);
        chk("b2b_idle_ready", 64'(in_ready),  64'd1);
        chk("b2b_idle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_second_taken", 64'(in_ready), 64'd0);
        set_ops(144, 63, 240, 12, 8, 3);
        dividend = '0;
        divisor  = '0;
        wait_out(lat);
        chk("b2b_second_latency", 64'(lat), 64'd8);
        check_results("b2b_second");
        out_ready = 1'b0;
        release_out();

        // Reset in BUSY cycle 3
        set_ops(250, 99, 31, 3, 4, 5);
        accept();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready",  64'(in_ready),  64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_quotient",  64'(quotient),  64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            chk("abort_stays_idle", 64'(out_valid), 64'd0);
        end
        set_ops(144, 144, 144, 12, 12, 12);
        accept();
        wait_out(lat);
        chk("abort_new_latency", 64'(lat), 64'd8);
        check_results("abort_new");
        release_out();

        // Random loopback
        for (int n = 0; n < 1000; n++) begin
            set_ops(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 255)), int'($urandom_range(1, 15)),
                    int'($urandom_range(1, 15)), int'($urandom_range(1, 15)));
            accept();
            wait_out(lat);
            chk("rand_latency", 64'(lat), 64'd8);
            check_results("rand");
            for (int i = 0; i < ND; i++) begin
                chk("loop_eq", 64'(int'(quotient[i*DW +: DW]) * b_m[i]
                                   + int'(remainder[i*NB +: NB])), 64'(a_m[i]));
                chk("loop_lt", 64'(int'(remainder[i*NB +: NB]) < b_m[i]), 64'd1);
            end
            if (($urandom & 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                @(negedge clk);
                chk("rand_bp_hold", 64'(out_valid), 64'd1);
            end
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
